// File: rtl/mont_redc_if.sv
// Request/response bundle for mont_redc. The master drives the operands and start.
// The slave returns the reduced result with done/busy status.
interface mont_redc_if #(
    parameter int WIDTH   = 8,
    parameter int R_WIDTH = 8,
    parameter int S       = 2
);
    logic                    start;
    logic [S-1:0][WIDTH-1:0] t;
    logic [S-1:0][WIDTH-1:0] n;
    logic [R_WIDTH-1:0]      n_prime;
    logic [S-1:0][WIDTH-1:0] result;
    logic                    done;
    logic                    busy;

    modport master (output start, t, n, n_prime, input result, done, busy);
    modport slave  (input start, t, n, n_prime, output result, done, busy);
endinterface

// File: rtl/mont_redc.sv
// Limb-serial Montgomery reduction: result = t * R^-1 mod n, with R = 2^(WIDTH*S).
// Define MONT_REDC_FINAL_SUB_EN to add the final conditional subtraction, which gives result < n.
module mont_redc #(
    parameter int WIDTH   = 8,
    parameter int R_WIDTH = 8,
    parameter int S       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mont_redc_if.slave bus
);
    localparam int CW = $clog2(S + 1);

    typedef logic [2*WIDTH:0]   mac_t;
    typedef logic [2*WIDTH-1:0] prod_t;

    typedef enum logic [2:0] {
        IDLE, CALC_M, ACC, TOP,
`ifdef MONT_REDC_FINAL_SUB_EN
        SUB, SEL,
`endif
        DONE
    } state_t;

    function automatic logic [WIDTH-1:0] calc_m(input logic [WIDTH-1:0] t0,
                                                input logic [R_WIDTH-1:0] np);
        return WIDTH'(prod_t'(t0) * prod_t'(np));
    endfunction

    function automatic mac_t mac(input logic [WIDTH-1:0] a, m, b, input logic [WIDTH:0] c);
        return mac_t'(a) + mac_t'(m) * mac_t'(b) + mac_t'(c);
    endfunction

`ifdef MONT_REDC_FINAL_SUB_EN
    function automatic logic [WIDTH:0] sub_limb(input logic [WIDTH-1:0] a, b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    endfunction
`endif

    state_t                  state;
    logic [S:0][WIDTH-1:0]   acc_t;
    logic [S-1:0][WIDTH-1:0] n_r;
    logic [R_WIDTH-1:0]      np_r;
    logic [WIDTH-1:0]        m_r;
    logic [WIDTH:0]          c_r;
    logic [CW-1:0]           j_r;
    logic [CW-1:0]           i_r;
    logic [S-1:0][WIDTH-1:0] result_r;
    logic                    done_r;
    logic                    busy_r;

    logic [WIDTH-1:0]        t_sel;
    logic [WIDTH-1:0]        n_sel;
    mac_t                    mac_v;
    prod_t                   top_v;
`ifdef MONT_REDC_FINAL_SUB_EN
    logic [S-1:0][WIDTH-1:0] d_r;
    logic                    bw_r;
    logic [WIDTH:0]          sub_v;
`else
    logic [S-1:0][WIDTH-1:0] top_low;
`endif

    // Limb j of T and n feeds both the multiply-accumulate and the serial subtract.
    always_comb begin
        t_sel = '0;
        n_sel = '0;
        for (int k = 0; k < S; k++) begin
            if (j_r == CW'(k)) begin
                t_sel = acc_t[k];
                n_sel = n_r[k];
            end
        end
        mac_v = mac(t_sel, m_r, n_sel, c_r);
        top_v = prod_t'(acc_t[S]) + prod_t'(c_r);
`ifdef MONT_REDC_FINAL_SUB_EN
        sub_v = sub_limb(t_sel, n_sel, bw_r);
`else
        top_low      = acc_t[S-1:0];
        top_low[S-1] = top_v[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc_t    <= '0;
            n_r      <= '0;
            np_r     <= '0;
            m_r      <= '0;
            c_r      <= '0;
            j_r      <= '0;
            i_r      <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
`ifdef MONT_REDC_FINAL_SUB_EN
            d_r      <= '0;
            bw_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_t  <= {{WIDTH{1'b0}}, bus.t};
                        n_r    <= bus.n;
                        np_r   <= bus.n_prime;
                        i_r    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC_M;
                    end
                end
                CALC_M: begin
                    m_r   <= calc_m(acc_t[0], np_r);
                    j_r   <= '0;
                    c_r   <= '0;
                    state <= ACC;
                end
                ACC: begin
                    // Limb 0 of T + m*n is zero by choice of m, so each sum lands one limb lower.
                    for (int k = 0; k < S - 1; k++) begin
                        if (j_r == CW'(k + 1)) acc_t[k] <= mac_v[WIDTH-1:0];
                    end
                    c_r <= mac_v[2*WIDTH:WIDTH];
                    if (j_r == CW'(S - 1)) state <= TOP;
                    else                   j_r   <= j_r + CW'(1);
                end
                TOP: begin
                    acc_t[S-1] <= top_v[WIDTH-1:0];
                    acc_t[S]   <= top_v[2*WIDTH-1:WIDTH];
                    i_r        <= i_r + CW'(1);
                    j_r        <= '0;
                    if (i_r == CW'(S - 1)) begin
`ifdef MONT_REDC_FINAL_SUB_EN
                        bw_r     <= 1'b0;
                        state    <= SUB;
`else
                        result_r <= top_low;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state    <= DONE;
`endif
                    end else begin
                        state <= CALC_M;
                    end
                end
`ifdef MONT_REDC_FINAL_SUB_EN
                SUB: begin
                    for (int k = 0; k < S; k++) begin
                        if (j_r == CW'(k)) d_r[k] <= sub_v[WIDTH-1:0];
                    end
                    bw_r <= sub_v[WIDTH];
                    if (j_r == CW'(S - 1)) state <= SEL;
                    else                   j_r   <= j_r + CW'(1);
                end
                SEL: begin
                    // A set top limb absorbs the borrow out of the low limbs.
                    result_r <= ((acc_t[S] != '0) || !bw_r) ? d_r : acc_t[S-1:0];
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= DONE;
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
endmodule

// File: doc/mont_redc.md
MONT_REDC -- requirements
Module: mont_redc

Interface
REQ-001 Parameters: WIDTH, default 8, limb width in bits.
REQ-002 Parameters: R_WIDTH, default 8, width of n_prime; SHALL equal WIDTH.
REQ-003 Parameters: S, default 2, number of limbs; R = 2^(WIDTH*S).
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start, input, 1, request pulse; accepted only in IDLE.
REQ-007 Port t, input, [WIDTH-1:0] x S, Montgomery-form operand; limb 0 is least significant; value < R.
REQ-008 Port n, input, [WIDTH-1:0] x S, odd modulus, little-endian limbs.
REQ-009 Port n_prime, input, R_WIDTH, -n^-1 mod 2^WIDTH.
REQ-010 Port result, output, [WIDTH-1:0] x S, t*R^-1 mod n (normal form).
REQ-011 Port done, output, 1, one-cycle completion pulse.
REQ-012 Port busy, output, 1, high from the cycle after acceptance until done.

Function
REQ-013 t, n and n_prime SHALL be latched on the accepting edge; later input changes SHALL have no effect on the operation in progress.
REQ-014 Datapath: S+1-limb accumulator T, initially {0, t}; one WIDTH x WIDTH multiply-accumulate per cycle.
REQ-015 States: IDLE, CALC_M, ACC, TOP, SUB, SEL, DONE.
REQ-016 CALC_M (1 cycle): m = (T[0]*n_prime) mod 2^WIDTH; the limb counter j is cleared.
REQ-017 ACC (S cycles, j = 0..S-1): {c, x} = T[j] + m*n[j] + c; writes T[j-1] = x for j > 0, discards x at j = 0 (always 0); c is WIDTH+1 bits.
REQ-018 TOP (1 cycle): {T[S], T[S-1]} = T[S] + c; the outer counter increments; if it reaches S, the next state is SUB, otherwise CALC_M.
REQ-019 SUB (S cycles): D = T - n computed limb-serially with borrow into a scratch register.
REQ-020 SEL (1 cycle): result = D if no final borrow, otherwise T[S-1:0]; then DONE.
REQ-021 DONE (1 cycle): done = 1, busy = 0, then IDLE.
REQ-022 Latency: done is high exactly S*(S+2)+S+2 cycles after the accepting edge (12 for S=2).
REQ-023 result SHALL hold its value from SEL until the SEL of the next operation.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 start asserted in the DONE cycle SHALL be ignored; it is accepted the next cycle in IDLE.
REQ-026 t = 0 SHALL yield result 0.
REQ-027 Result is valid for odd n and t < R; other inputs produce an undefined result but SHALL NOT hang the FSM.

Reset
REQ-028 Reset asserted SHALL immediately force: state IDLE, done 0, busy 0, result all-zero limbs, T and counters zero.
REQ-029 Reset mid-operation SHALL abandon the operation with no done pulse.
REQ-030 The first start after reset release SHALL be accepted normally.

Configuration
REQ-031 Macro MONT_REDC_FINAL_SUB_EN.
REQ-032 With MONT_REDC_FINAL_SUB_EN defined: SUB and SEL are present; result is < n; latency is per REQ-022.
REQ-033 Without the macro: SUB and SEL are removed; result = T[S-1:0], which lies in [0, 2n); latency is S*(S+2)+1.

Verification (WIDTH=8, S=2, n=16'hC2B3, n_prime=8'h85)
REQ-034 t=16'h3D4D (R mod n) -> result 16'h0001, done exactly 12 cycles after the accepting edge.
REQ-035 t=16'h7A9A (2R mod n) -> result 16'h0002; t=0 -> result 16'h0000.
REQ-036 start re-pulsed at cycles 3 and 11 of an operation -> exactly one done; result matches the first request.
REQ-037 rst_n low at cycle 5 of an operation -> done never pulses, result = 0; next start with t=16'h3D4D -> 16'h0001.
REQ-038 Back-to-back: start in the cycle after done -> accepted; results correct for both operations; start held high during DONE is not accepted until IDLE.
REQ-039 Macro undefined, t=16'h3D4D -> result 16'h0001 (reduced modulo n in the checker), done at cycle 9.
